// File: rtl/sa_ctrl_pkg.sv
// Shared types and default widths for the systolic-array job sequencer.
package sa_ctrl_pkg;

  localparam int unsigned SA_ADDR_W      = 32;
  localparam int unsigned SA_BIT_TRANS   = 8;
  localparam int unsigned SA_BLK_W       = 16;
  localparam int unsigned SA_QUEUE_DEPTH = 4;
  localparam int unsigned SA_TIMEOUT_W   = 24;
  localparam int unsigned SA_JOBS_W      = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_PARAM = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_code_e;

  typedef struct packed {
    logic [SA_ADDR_W-1:0]    rd_base;
    logic [SA_ADDR_W-1:0]    wr_base;
    logic [SA_BIT_TRANS-1:0] num_trans;
    logic [SA_BLK_W-1:0]     max_blk;
  } job_desc_t;

endpackage

// File: rtl/sa_job_sequencer_if.sv
// Job-submit and core-launch signal bundle between CSR block, sequencer and sa_core.
interface sa_job_sequencer_if
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = SA_ADDR_W,
  parameter int unsigned BIT_TRANS = SA_BIT_TRANS,
  parameter int unsigned BLK_W     = SA_BLK_W
);
  logic                 i_start;
  logic [ADDR_W-1:0]    i_rd_base;
  logic [ADDR_W-1:0]    i_wr_base;
  logic [BIT_TRANS-1:0] i_num_trans;
  logic [BLK_W-1:0]     i_max_blk;
  logic                 i_core_done;
  logic                 o_core_start;
  logic [ADDR_W-1:0]    o_rd_base;
  logic [ADDR_W-1:0]    o_wr_base;
  logic [BIT_TRANS-1:0] o_num_trans;
  logic [BLK_W-1:0]     o_max_blk;

  modport slave (
    input  i_start, i_rd_base, i_wr_base, i_num_trans, i_max_blk, i_core_done,
    output o_core_start, o_rd_base, o_wr_base, o_num_trans, o_max_blk
  );

  modport master (
    output i_start, i_rd_base, i_wr_base, i_num_trans, i_max_blk, i_core_done,
    input  o_core_start, o_rd_base, o_wr_base, o_num_trans, o_max_blk
  );
endinterface

// File: rtl/sa_desc_fifo.sv
// Synchronous descriptor FIFO; wrap-bit pointers distinguish full from empty.
module sa_desc_fifo
  import sa_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = SA_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             push,
  input  job_desc_t        push_data,
  input  logic             pop,
  output job_desc_t        pop_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  job_desc_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign level    = LVL_W'(wr_ptr - rd_ptr);
  assign do_pop   = pop && !empty;
  // A full queue still accepts when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/sa_job_sequencer.sv
// Job front-end: queues descriptors, launches them to sa_core, watchdog/abort and sticky irq/error.
module sa_job_sequencer
  import sa_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_W      = SA_ADDR_W,
  parameter  int unsigned BIT_TRANS   = SA_BIT_TRANS,
  parameter  int unsigned BLK_W       = SA_BLK_W,
  parameter  int unsigned QUEUE_DEPTH = SA_QUEUE_DEPTH,
  parameter  int unsigned TIMEOUT_W   = SA_TIMEOUT_W,
  localparam int unsigned LVL_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  sa_job_sequencer_if.slave    bus,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  input  logic                 i_abort,
  input  logic                 i_irq_en,
  input  logic                 i_irq_clr,
  output logic                 o_busy,
  output logic                 o_q_full,
  output logic [LVL_W-1:0]     o_q_level,
  output logic [SA_JOBS_W-1:0] o_jobs_done,
  output logic                 o_irq,
  output logic                 o_error,
  output logic [1:0]           o_err_code
);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_LAUNCH = 3'(LAUNCH);
  localparam logic [2:0] S_RUN    = 3'(RUN);
  localparam logic [2:0] S_DONE   = 3'(DONE);
  localparam logic [2:0] S_ERR    = 3'(ERR);

  logic [2:0]           state;
  logic [2:0]           state_n;
  logic [TIMEOUT_W-1:0] wd;
  job_desc_t            push_desc;
  job_desc_t            pop_desc;
  logic                 q_full, q_empty;
  logic [LVL_W-1:0]     q_level;
  logic                 abort_eff, push_try, zero_field, push_ok, pop;
  logic                 bad_param, overflow, timeout_hit, done_evt, enter_err;
  logic                 err_set, irq_set, flush;
  logic [1:0]           err_new;

  // Abort with nothing running and nothing queued has no effect.
  assign abort_eff   = i_abort && !(state == S_IDLE && q_empty);
  assign push_try    = bus.i_start && (state != S_ERR) && !abort_eff;
  assign zero_field  = (bus.i_num_trans == '0) || (bus.i_max_blk == '0);
  assign push_ok     = push_try && !zero_field;
  assign pop         = (state == S_LAUNCH) && !abort_eff;
  assign bad_param   = push_try && zero_field;
  assign overflow    = push_ok && q_full && !pop;
  assign timeout_hit = (state == S_RUN) && (i_timeout != '0) && (wd == i_timeout);
  assign done_evt    = (state == S_RUN) && (state_n == S_DONE);
  assign enter_err   = (state != S_ERR) && (state_n == S_ERR);
  assign flush       = abort_eff || enter_err;
  assign err_set     = bad_param || overflow || enter_err;
  assign irq_set     = err_set || (done_evt && i_irq_en);
  assign err_new     = enter_err ? 2'(ERR_TIMEOUT) :
                       overflow  ? 2'(ERR_OVERFLOW) : 2'(ERR_BAD_PARAM);

  assign push_desc = '{rd_base:   SA_ADDR_W'(bus.i_rd_base),
                       wr_base:   SA_ADDR_W'(bus.i_wr_base),
                       num_trans: SA_BIT_TRANS'(bus.i_num_trans),
                       max_blk:   SA_BLK_W'(bus.i_max_blk)};

  sa_desc_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .push          (push_ok),
    .push_data     (push_desc),
    .pop           (pop),
    .pop_data      (pop_desc),
    .flush         (flush),
    .full          (q_full),
    .empty         (q_empty),
    .level         (q_level)
  );

  assign o_busy    = (state != S_IDLE) || !q_empty;
  assign o_q_full  = q_full;
  assign o_q_level = q_level;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= S_IDLE;
    else                state <= state_n;
  end

  // Core completion outranks the watchdog; abort outranks everything.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (!q_empty) state_n = S_LAUNCH;
      S_LAUNCH: state_n = S_RUN;
      S_RUN: begin
        if (bus.i_core_done)  state_n = S_DONE;
        else if (timeout_hit) state_n = S_ERR;
      end
      S_DONE:   state_n = q_empty ? S_IDLE : S_LAUNCH;
      S_ERR:    if (i_irq_clr) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (abort_eff) state_n = S_ERR;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bus.o_core_start <= 1'b0;
      bus.o_rd_base    <= '0;
      bus.o_wr_base    <= '0;
      bus.o_num_trans  <= '0;
      bus.o_max_blk    <= '0;
      wd               <= '0;
      o_jobs_done      <= '0;
    end else begin
      bus.o_core_start <= (state_n == S_RUN);
      if (pop) begin
        bus.o_rd_base   <= ADDR_W'(pop_desc.rd_base);
        bus.o_wr_base   <= ADDR_W'(pop_desc.wr_base);
        bus.o_num_trans <= BIT_TRANS'(pop_desc.num_trans);
        bus.o_max_blk   <= BLK_W'(pop_desc.max_blk);
      end
      // Watchdog holds the index of the current RUN cycle, starting at 1.
      if (state == S_LAUNCH)   wd <= TIMEOUT_W'(1);
      else if (state == S_RUN) wd <= wd + TIMEOUT_W'(1);
      if (done_evt) o_jobs_done <= o_jobs_done + SA_JOBS_W'(1);
    end
  end

  // Sticky status: a same-cycle set beats clear; otherwise the first error code is kept.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      o_irq      <= 1'b0;
      o_error    <= 1'b0;
      o_err_code <= 2'(ERR_NONE);
    end else begin
      if (irq_set)        o_irq <= 1'b1;
      else if (i_irq_clr) o_irq <= 1'b0;
      if (err_set)        o_error <= 1'b1;
      else if (i_irq_clr) o_error <= 1'b0;
      if (err_set && (i_irq_clr || o_err_code == 2'(ERR_NONE))) o_err_code <= err_new;
      else if (!err_set && i_irq_clr)                           o_err_code <= 2'(ERR_NONE);
    end
  end

endmodule
